// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: stage FSM encoding, phase tags, enable bundle,
// default widths and the fixed 3x3 Laplacian weight table.
package cnn_pkg;

  localparam int CNN_DATA_W   = 8;
  localparam int CNN_N_WORDS  = 9;
  localparam int CNN_ADDR_W   = 4;
  localparam int CNN_ACC_W    = 20;
  localparam int CNN_HOLD_CYC = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    MAC  = 3'd2,
    SHOW = 3'd3,
    HOLD = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE = 2'd0,
    PH_MEM  = 2'd1,
    PH_CMP  = 2'd2,
    PH_DSP  = 2'd3
  } phase_t;

  typedef struct packed {
    logic mem;
    logic cmp;
    logic dsp;
  } en_t;

  localparam logic signed [CNN_DATA_W-1:0] W [CNN_N_WORDS] = '{
    8'sd0, -8'sd1, 8'sd0,
    -8'sd1, 8'sd4, -8'sd1,
    8'sd0, -8'sd1, 8'sd0
  };

  function automatic logic multi_hot(input en_t e);
    return (e.mem & e.cmp) | (e.mem & e.dsp) | (e.cmp & e.dsp);
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate; clr zeroes the accumulator and wins over en.
// Latency: sum is combinational, the accumulator updates on the next edge.
// Backpressure: none; the caller gates en.
module mac_unit
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int ACC_W  = CNN_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = a * b;
  // Explicit sign extension of the product; addition wraps at ACC_W.
  assign sum  = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/stage_executor.sv
// Executes memory/compute/display phases for the controller; RELU_EN selects ReLU display.
// Latency: load N_WORDS+1, compute N_WORDS, display HOLD_CYC cycles from the enable edge.
// Backpressure: a missing mem_valid stalls LOAD indefinitely; done held until enable drops.
module stage_executor
  import cnn_pkg::*;
#(
  parameter int DATA_W   = CNN_DATA_W,
  parameter int N_WORDS  = CNN_N_WORDS,
  parameter int ADDR_W   = CNN_ADDR_W,
  parameter int ACC_W    = CNN_ACC_W,
  parameter int HOLD_CYC = CNN_HOLD_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_memory,
  input  logic                    enable_compute,
  input  logic                    enable_display,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_valid,
  output logic                    memory_done,
  output logic                    compute_done,
  output logic                    display_done,
  output logic [7:0]              display_data,
  output logic                    display_valid,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    error
);

  localparam int CW = ADDR_W + 1;
  localparam int IW = $clog2(N_WORDS);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N_WORDS - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(N_WORDS);
  localparam logic [HW-1:0] SHOW_LAST = HW'(HOLD_CYC - 1);
  localparam logic signed [ACC_W-1:0] DISP_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] DISP_MIN = ACC_W'(-128);

  en_t    en_now, en_prev, en_rise;
  logic   multi, any_en, own_en, blocked_q;
  state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic [CW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [HW-1:0] show_q, show_d;
  logic   mac_clr, mac_en, acc_load, buf_we;
  logic signed [ACC_W-1:0]  mac_sum;
  logic signed [DATA_W-1:0] win_buf [N_WORDS];
  logic signed [7:0]        clamped;

  assign en_now  = '{mem: enable_memory, cmp: enable_compute, dsp: enable_display};
  assign en_rise = en_now & ~en_prev;
  assign multi   = multi_hot(en_now);
  assign any_en  = |en_now;

  always_comb begin
    own_en = 1'b0;
    unique case (phase_q)
      PH_MEM:  own_en = en_now.mem;
      PH_CMP:  own_en = en_now.cmp;
      PH_DSP:  own_en = en_now.dsp;
      default: own_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    show_d   = show_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    acc_load = 1'b0;
    if (multi) begin
      state_d = IDLE;
      phase_d = PH_NONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          rd_d   = '0;
          wr_d   = '0;
          show_d = '0;
          // After an overlap, edges are ignored until every enable has been low.
          if (!blocked_q) begin
            if (en_rise.mem) begin
              state_d = LOAD;
              phase_d = PH_MEM;
            end else if (en_rise.cmp) begin
              state_d = MAC;
              phase_d = PH_CMP;
              mac_clr = 1'b1;
            end else if (en_rise.dsp) begin
              state_d = SHOW;
              phase_d = PH_DSP;
            end
          end
        end
        LOAD: begin
          if (!en_now.mem) begin
            state_d = IDLE;
            phase_d = PH_NONE;
          end else begin
            if (rd_q != CNT_END) rd_d = rd_q + 1'b1;
            if (mem_valid) begin
              wr_d = wr_q + 1'b1;
              if (wr_q == CNT_LAST) state_d = HOLD;
            end
          end
        end
        MAC: begin
          if (!en_now.cmp) begin
            state_d = IDLE;
            phase_d = PH_NONE;
          end else begin
            mac_en = 1'b1;
            rd_d   = rd_q + 1'b1;
            if (rd_q == CNT_LAST) begin
              state_d  = HOLD;
              acc_load = 1'b1;
            end
          end
        end
        SHOW: begin
          if (!en_now.dsp) begin
            state_d = IDLE;
            phase_d = PH_NONE;
          end else begin
            show_d = show_q + 1'b1;
            if (show_q == SHOW_LAST) state_d = HOLD;
          end
        end
        HOLD: begin
          if (!own_en) begin
            state_d = IDLE;
            phase_d = PH_NONE;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = PH_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      phase_q   <= PH_NONE;
      rd_q      <= '0;
      wr_q      <= '0;
      show_q    <= '0;
      en_prev   <= '0;
      blocked_q <= 1'b0;
      error     <= 1'b0;
      acc_out   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      show_q    <= show_d;
      en_prev   <= en_now;
      blocked_q <= multi | (blocked_q & any_en);
      error     <= error | multi;
      if (mac_clr) begin
        acc_out <= '0;
      end else if (acc_load) begin
        acc_out <= mac_sum;
      end
    end
  end

  // Window storage needs no reset; contents are only meaningful after a full LOAD.
  assign buf_we = (state_q == LOAD) && en_now.mem && !multi && mem_valid && (wr_q < CNT_END);

  always_ff @(posedge clk) begin
    if (buf_we) win_buf[wr_q[IW-1:0]] <= mem_rdata;
  end

  mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (win_buf[rd_q[IW-1:0]]),
    .b   (W[rd_q[IW-1:0]]),
    .sum (mac_sum)
  );

  assign mem_rd        = (state_q == LOAD) && (rd_q < CNT_END);
  assign mem_addr      = mem_rd ? rd_q[ADDR_W-1:0] : '0;
  assign memory_done   = (state_q == HOLD) && (phase_q == PH_MEM);
  assign compute_done  = (state_q == HOLD) && (phase_q == PH_CMP);
  assign display_done  = (state_q == HOLD) && (phase_q == PH_DSP);
  assign display_valid = (state_q == SHOW);

  always_comb begin
    clamped = acc_out[7:0];
    if (acc_out > DISP_MAX) begin
      clamped = 8'h7F;
    end else if (acc_out < DISP_MIN) begin
      clamped = 8'h80;
    end
  end

  always_comb begin
    display_data = 8'h00;
    if (display_valid) begin
`ifdef RELU_EN
      display_data = clamped[7] ? 8'h00 : clamped;
`else
      display_data = clamped;
`endif
    end
  end

endmodule

// File: tb/tb_stage_executor.sv
// Scoreboard bench for stage_executor: stimulus queues expected events with their cycle,
// a monitor pops and compares whenever the DUT shows a read, done edge or display beat.
module tb_stage_executor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_memory = 1'b0;
  logic        enable_compute = 1'b0;
  logic        enable_display = 1'b0;
  logic        mem_rd;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_valid = 1'b0;
  logic        memory_done, compute_done, display_done;
  logic [7:0]  display_data;
  logic        display_valid;
  logic [19:0] acc_out;
  logic        error;

  stage_executor dut (
    .clk            (clk),
    .rst            (rst),
    .enable_memory  (enable_memory),
    .enable_compute (enable_compute),
    .enable_display (enable_display),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_valid      (mem_valid),
    .memory_done    (memory_done),
    .compute_done   (compute_done),
    .display_done   (display_done),
    .display_data   (display_data),
    .display_valid  (display_valid),
    .acc_out        (acc_out),
    .error          (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  localparam int EV_RD = 0, EV_MD = 1, EV_CD = 2, EV_DV = 3, EV_DD = 4;
  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;
  ev_t sb[$];

  logic [7:0] mem_img [9];
  logic [7:0] imgs [5][9];
  int acc_exp [5];
  int disp_exp [5];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic sb_event(input int kind, input int val);
    ev_t e;
    n_checks++;
    if (sb.size() == 0) begin
      $display("FAIL sb_unexpected: kind %0d val %0d at cycle %0d, expected no event", kind, val, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind == kind && e.val == val && e.cyc == cyc) n_pass++;
      else $display("FAIL sb_event: got kind %0d val %0d cycle %0d, expected kind %0d val %0d cycle %0d",
                    kind, val, cyc, e.kind, e.val, e.cyc);
    end
  endtask

  // Monitor: sample at the falling edge, well away from the DUT's active edge.
  initial begin
    logic md_p, cd_p, dd_p;
    md_p = 1'b0;
    cd_p = 1'b0;
    dd_p = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd) sb_event(EV_RD, int'(mem_addr));
      if (memory_done && !md_p) sb_event(EV_MD, 0);
      if (compute_done && !cd_p) sb_event(EV_CD, int'($signed(acc_out)));
      if (display_valid) sb_event(EV_DV, int'(display_data));
      if (display_done && !dd_p) sb_event(EV_DD, 0);
      md_p = memory_done;
      cd_p = compute_done;
      dd_p = display_done;
    end
  end

  // Memory model: data and valid exactly one cycle after each read strobe.
  initial begin
    logic       p;
    logic [3:0] a;
    forever begin
      @(negedge clk);
      p = mem_rd;
      a = mem_addr;
      @(posedge clk);
      #1;
      mem_valid = p;
      mem_rdata = (p && a < 4'd9) ? mem_img[a] : 8'h00;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic logic flag(input int k);
    case (k)
      0:       return memory_done;
      1:       return compute_done;
      2:       return display_done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_flag(input int k, input string nm);
    int n;
    n = 0;
    while (!flag(k) && n < 40) begin
      tick();
      n++;
    end
    if (!flag(k)) begin
      n_checks++;
      $display("FAIL %s: got no done after %0d cycles, expected done within 40", nm, n);
    end
  endtask

  task automatic do_load(input int i);
    int c;
    for (int k = 0; k < 9; k++) mem_img[k] = imgs[i][k];
    c = cyc;
    for (int k = 0; k < 9; k++) sb.push_back('{EV_RD, k, c + 1 + k});
    sb.push_back('{EV_MD, 0, c + 11});
    enable_memory = 1'b1;
    wait_flag(0, "load_done");
    enable_memory = 1'b0;
    tick();
    chk("mem_done_clear", int'(memory_done), 0);
  endtask

  task automatic do_compute(input int exp);
    int c;
    c = cyc;
    sb.push_back('{EV_CD, exp, c + 10});
    enable_compute = 1'b1;
    wait_flag(1, "compute_done");
    chk("acc_out", int'($signed(acc_out)), exp);
    enable_compute = 1'b0;
    tick();
    chk("cmp_done_clear", int'(compute_done), 0);
  endtask

  task automatic do_display(input int exp);
    int c;
    c = cyc;
    for (int k = 0; k < 4; k++) sb.push_back('{EV_DV, exp, c + 1 + k});
    sb.push_back('{EV_DD, 0, c + 5});
    enable_display = 1'b1;
    wait_flag(2, "display_done");
    chk("disp_valid_off", int'(display_valid), 0);
    enable_display = 1'b0;
    tick();
    chk("disp_done_clear", int'(display_done), 0);
  endtask

  initial begin
    int c;
    int n;
    imgs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    imgs[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
    imgs[2] = '{8'h00, 8'h4B, 8'h00, 8'h4B, 8'h00, 8'h4B, 8'h00, 8'h4B, 8'h00};
    imgs[3] = '{8'h00, 8'hCE, 8'h00, 8'hCE, 8'h64, 8'hCE, 8'h00, 8'hCE, 8'h00};
    imgs[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hF6, 8'h00, 8'h00, 8'h00, 8'h00};
    acc_exp = '{0, 40, -300, 600, -40};
`ifdef RELU_EN
    disp_exp = '{0, 40, 0, 127, 0};
`else
    disp_exp = '{0, 40, 128, 127, 216};
`endif
    for (int k = 0; k < 9; k++) mem_img[k] = 8'h00;

    rst = 1'b0;
    repeat (3) tick();
    chk("rst_mem_rd", int'(mem_rd), 0);
    chk("rst_flags", int'({memory_done, compute_done, display_done, display_valid, error}), 0);
    chk("rst_acc", int'(acc_out), 0);
    chk("rst_disp", int'(display_data), 0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      do_load(i);
      do_compute(acc_exp[i]);
      do_display(disp_exp[i]);
    end

    // Abort on the third MAC cycle, then a full recompute of the same window.
    enable_compute = 1'b1;
    repeat (3) tick();
    enable_compute = 1'b0;
    repeat (12) tick();
    chk("abort_no_done", int'(compute_done), 0);
    do_compute(-40);

    // Asynchronous reset in the middle of a load, at address 5.
    for (int k = 0; k < 9; k++) mem_img[k] = imgs[2][k];
    c = cyc;
    for (int k = 0; k < 6; k++) sb.push_back('{EV_RD, k, c + 1 + k});
    enable_memory = 1'b1;
    n = 0;
    while (!(mem_rd && mem_addr == 4'd5) && n < 20) begin
      tick();
      n++;
    end
    if (!(mem_rd && mem_addr == 4'd5)) begin
      n_checks++;
      $display("FAIL midload_wait: got no read of addr 5 after %0d cycles, expected one", n);
    end
    rst = 1'b0;
    #1;
    chk("midrst_mem", int'({mem_rd, mem_addr}), 0);
    chk("midrst_acc", int'(acc_out), 0);
    chk("midrst_flags", int'({memory_done, compute_done, display_done, display_valid, error}), 0);
    enable_memory = 1'b0;
    tick();
    rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", int'(mem_rd), 0);

    // Overlapping enables: sticky error, no phase runs.
    enable_memory  = 1'b1;
    enable_display = 1'b1;
    repeat (4) tick();
    chk("ovl_error", int'(error), 1);
    chk("ovl_no_rd", int'(mem_rd), 0);
    chk("ovl_no_done", int'({memory_done, display_done, display_valid}), 0);
    enable_display = 1'b0;
    repeat (3) tick();
    chk("ovl_locked", int'(mem_rd), 0);
    enable_memory = 1'b0;
    tick();
    chk("err_sticky", int'(error), 1);
    do_load(3);
    do_compute(600);
    do_display(127);
    chk("err_still_set", int'(error), 1);

    repeat (3) tick();
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
